// File: rtl/jk_fsm_sequencer.sv
// rtl/jk_fsm_sequencer.sv - stimulus/check sequencer for the 2-bit JK state machine
//
// Purpose: per accepted command, clears the target FSM, shifts a pattern onto its
// w input LSB first, samples the resulting state and compares it with an expected value.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   start     in   command strobe, honoured only in IDLE
//   pattern   in   [PAT_W-1:0] w bits, LSB first
//   length    in   [LEN_W-1:0] bit count, saturated to PAT_W
//   expect_y  in   [1:0] expected target state after the last bit
//   abort     in   ends an active command (CLEAR/DRIVE only)
//   fsm_y     in   [1:0] target FSM state
//   fsm_w     out  registered w drive to the target
//   fsm_rst   out  registered active-high clear to the target
//   busy      out  high outside IDLE
//   done      out  one-cycle completion pulse
//   pass      out  compare result, valid from done until the next accept
//   final_y   out  [1:0] sampled target state, valid with pass
//   steps     out  [LEN_W-1:0] bits actually driven
module jk_fsm_sequencer #(
    parameter int PAT_W = 16,
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] length,
    input  logic [1:0]       expect_y,
    input  logic             abort,
    input  logic [1:0]       fsm_y,
    output logic             fsm_w,
    output logic             fsm_rst,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [1:0]       final_y,
    output logic [LEN_W-1:0] steps
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DRIVE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    state_t             state_q;
    logic [PAT_W-1:0]   pat_q;      // shifted right as bits are driven
    logic [LEN_W-1:0]   len_q;
    logic [1:0]         exp_q;
    logic [LEN_W-1:0]   cnt_q;
    logic               fsm_w_q;
    logic               fsm_rst_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [1:0]         final_y_q;
    logic [LEN_W-1:0]   steps_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            exp_q     <= '0;
            cnt_q     <= '0;
            fsm_w_q   <= 1'b0;
            fsm_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            final_y_q <= '0;
            steps_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    fsm_rst_q <= 1'b0;
                    fsm_w_q   <= 1'b0;
                    if (start) begin
                        pat_q     <= pattern;
                        len_q     <= (length > LEN_MAX) ? LEN_MAX : length;
                        exp_q     <= expect_y;
                        cnt_q     <= '0;
                        pass_q    <= 1'b0;
                        final_y_q <= '0;
                        steps_q   <= '0;
                        fsm_rst_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    fsm_rst_q <= 1'b0;
                    if (abort) begin
                        fsm_w_q   <= 1'b0;
                        final_y_q <= fsm_y;
                        pass_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end else if (len_q != '0) begin
                        // First bit goes out together with the release of the clear.
                        fsm_w_q <= pat_q[0];
                        pat_q   <= pat_q >> 1;
                        state_q <= ST_DRIVE;
                    end else begin
                        fsm_w_q <= 1'b0;
                        state_q <= ST_CHECK;
                    end
                end
                ST_DRIVE: begin
                    if (abort) begin
                        // Abort beats the final drive edge; the aborted bit is not counted.
                        fsm_w_q   <= 1'b0;
                        final_y_q <= fsm_y;
                        pass_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        steps_q <= steps_q + ONE;
                        cnt_q   <= cnt_q + ONE;
                        if (cnt_q == len_q - ONE) begin
                            fsm_w_q <= 1'b0;
                            state_q <= ST_CHECK;
                        end else begin
                            fsm_w_q <= pat_q[0];
                            pat_q   <= pat_q >> 1;
                        end
                    end
                end
                ST_CHECK: begin
                    fsm_w_q   <= 1'b0;
                    final_y_q <= fsm_y;
                    pass_q    <= (fsm_y == exp_q);
                    done_q    <= 1'b1;
                    state_q   <= ST_DONE;
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    fsm_w_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign fsm_w   = fsm_w_q;
    assign fsm_rst = fsm_rst_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign final_y = final_y_q;
    assign steps   = steps_q;

endmodule

// File: tb/tb_jk_fsm_sequencer.sv
// tb/tb_jk_fsm_sequencer.sv - self-checking bench for jk_fsm_sequencer
module tb_jk_fsm_sequencer;

    localparam int PAT_W = 16;
    localparam int LEN_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [LEN_W-1:0] length = '0;
    logic [1:0]       expect_y = '0;
    logic             abort = 1'b0;
    logic [1:0]       fsm_y;
    logic             fsm_w;
    logic             fsm_rst;
    logic             busy;
    logic             done;
    logic             pass;
    logic [1:0]       final_y;
    logic [LEN_W-1:0] steps;

    jk_fsm_sequencer #(.PAT_W(PAT_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .length(length),
        .expect_y(expect_y), .abort(abort), .fsm_y(fsm_y), .fsm_w(fsm_w),
        .fsm_rst(fsm_rst), .busy(busy), .done(done), .pass(pass),
        .final_y(final_y), .steps(steps)
    );

    always #5 clk = ~clk;

    // Target JK FSM reference: synchronous active-high clear.
    logic [1:0] ty = 2'b00;
    always @(posedge clk) begin
        if (fsm_rst) ty <= 2'b00;
        else case (ty)
            2'b00: ty <= fsm_w ? 2'b10 : 2'b00;
            2'b10: ty <= 2'b11;
            2'b11: ty <= 2'b01;
            default: ty <= fsm_w ? 2'b10 : 2'b00;
        endcase
    end
    assign fsm_y = ty;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] pat;
        logic [4:0]  len;
        logic [1:0]  ey;
        logic [1:0]  fy;
        logic        p;
        int          st;
        logic        pulse;
    } vec_t;

    typedef struct {
        logic [1:0] fy;
        logic       p;
        int         st;
        int         lat;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[7];
    int   total = 0;
    int   bad = 0;
    int   acc = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input logic [1:0] fy, input logic p, input int st, input int lat);
        exp_t e;
        e.fy = fy; e.p = p; e.st = st; e.lat = lat;
        sbq.push_back(e);
    endtask

    task automatic issue(input logic [15:0] pat, input logic [4:0] len, input logic [1:0] ey,
                         input logic ab);
        @(negedge clk);
        pattern = pat; length = len; expect_y = ey; start = 1'b1; abort = ab;
        @(posedge clk);
        #1;
        acc = cyc;
        abort = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{16'h0001, 5'd1,  2'b10, 2'b10, 1'b1, 1,  1'b0};
        vecs[1] = '{16'h0001, 5'd4,  2'b00, 2'b00, 1'b1, 4,  1'b0};
        vecs[2] = '{16'h0005, 5'd3,  2'b11, 2'b01, 1'b0, 3,  1'b1};
        vecs[3] = '{16'h0000, 5'd0,  2'b00, 2'b00, 1'b1, 0,  1'b0};
        vecs[4] = '{16'hFFFF, 5'd31, 2'b10, 2'b10, 1'b1, 16, 1'b0};
        vecs[5] = '{16'h0003, 5'd2,  2'b11, 2'b11, 1'b1, 2,  1'b0};
        vecs[6] = '{16'h0006, 5'd5,  2'b01, 2'b00, 1'b0, 5,  1'b1};

        fork
            forever begin
                @(negedge clk);
                if (rst && done) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk("final_y", int'(final_y), int'(e.fy));
                        chk("pass", int'(pass), int'(e.p));
                        chk("steps", int'(steps), e.st);
                        chk("done_latency", cyc - acc + 1, e.lat);
                        chk("done_fsm_w", int'(fsm_w), 0);
                    end
                end
            end
        join_none

        // Reset and idle.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_fsm_rst", int'(fsm_rst), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_final_y", int'(final_y), 0);
        chk("rst_steps", int'(steps), 0);
        chk("rst_fsm_w", int'(fsm_w), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_fsm_rst", int'(fsm_rst), 0);
        chk("rel_busy", int'(busy), 0);
        repeat (2) @(negedge clk);

        // Table-driven commands.
        for (int i = 0; i < 7; i++) begin
            int el;
            el = (vecs[i].len > 5'd16) ? 16 : int'(vecs[i].len);
            push_exp(vecs[i].fy, vecs[i].p, vecs[i].st, 3 + el);
            issue(vecs[i].pat, vecs[i].len, vecs[i].ey, 1'b0);
            chk("clear_fsm_rst", int'(fsm_rst), 1);
            chk("clear_fsm_w", int'(fsm_w), 0);
            chk("clear_busy", int'(busy), 1);
            if (vecs[i].pulse) begin
                @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("start_ignored_busy", int'(busy), 1);
            end
            wait_idle();
        end

        // start and abort together in IDLE: start wins, command runs normally.
        push_exp(2'b10, 1'b1, 1, 4);
        issue(16'h0001, 5'd1, 2'b10, 1'b1);
        wait_idle();

        // Abort in the second DRIVE cycle of a length-8 command.
        push_exp(2'b10, 1'b0, 1, 4);
        issue(16'h00FF, 5'd8, 2'b10, 1'b0);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_fsm_w", int'(fsm_w), 0);
        wait_idle();

        // Reset during DRIVE.
        issue(16'h00FF, 5'd8, 2'b00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_fsm_rst", int'(fsm_rst), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_fsm_w", int'(fsm_w), 0);
        chk("midrst_steps", int'(steps), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_rel_fsm_rst", int'(fsm_rst), 0);
        chk("midrst_rel_busy", int'(busy), 0);
        repeat (4) @(negedge clk);

        chk("pending_done", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jk_fsm_sequencer.md
Name: jk_fsm_sequencer

Overview:
- Controller that sequences the 2-bit JK state-machine block (inputs clk/rst/w, output y[1:0]).
- Per command it clears the target FSM, drives a programmed serial pattern onto its `w` input one bit per clock, samples the resulting state and compares it against an expected value.
- Used as the stimulus/check engine in front of the JK FSM in the digital-systems lab top level.

Parameters:
- PAT_W, 16, width of the pattern register (maximum bits per command).
- LEN_W, 5, width of the length field; length values above PAT_W saturate to PAT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  command strobe; accepted only in IDLE.
- pattern  in  PAT_W  w bits, applied LSB first; captured on accept.
- length  in  LEN_W  number of bits to drive; captured on accept.
- expect_y  in  2  expected target state after the last bit; captured on accept.
- abort  in  1  terminates an active command.
- fsm_y  in  2  state output of the target FSM.
- fsm_w  out  1  registered w drive to the target FSM.
- fsm_rst  out  1  registered active-high clear to the target FSM.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- pass  out  1  result; valid from done until the next accept.
- final_y  out  2  sampled target state; valid with pass.
- steps  out  LEN_W  number of bits actually driven.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - state=IDLE; fsm_w=0; fsm_rst=1; busy=0; done=0; pass=0; final_y=00; steps=0.
  - Internal pattern, length, expect and count registers are 0.
- After rst deasserts, fsm_rst drops to 0 on the first clk edge.
- State machine, one transition per clk edge:
  - IDLE: on start=1, capture the inputs (len = min(length, PAT_W)), clear pass/final_y/steps, go to CLEAR. start is ignored in every other state.
  - CLEAR: one cycle with fsm_rst=1 and fsm_w=0. Go to DRIVE if len>0, else CHECK.
  - DRIVE: during cycle k, fsm_w=pattern[k] and fsm_rst=0; steps increments at each edge. After len cycles, go to CHECK.
  - CHECK: one cycle with fsm_w=0. At the closing edge: final_y<=fsm_y; pass<=(fsm_y==expect_y); go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start accepted at edge 0; CLEAR is cycle 1; DRIVE is cycles 2..1+len; CHECK is cycle 2+len; done is high in cycle 3+len.
- Abort:
  - In DRIVE or CLEAR, abort=1 goes to DONE next edge with fsm_w=0, pass=0, final_y=fsm_y sampled at that edge. steps holds the bits driven so far.
  - abort in IDLE, CHECK or DONE is ignored.
  - abort and the last DRIVE edge in the same cycle: abort wins.
- start and abort together in IDLE: start is accepted and abort ignored.
- All outputs are registered; no combinational paths from inputs to outputs.
- fsm_w is 0 outside DRIVE.
- Counters: the count does not wrap; len=PAT_W drives exactly PAT_W bits.
- Reset mid-command: immediate return to the reset values. fsm_rst=1 holds the target FSM cleared.
- Target FSM transitions (reference model for checking): 00 -w-> 10 (w=1) / 00 (w=0); 10 -> 11; 11 -> 01; 01 -w-> 10 / 00.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release -> fsm_rst=1 then 0 after the first edge; busy=0, done=0, all outputs zero.
- pattern=0x0001, length=1, expect_y=10 -> one DRIVE cycle with fsm_w=1; done at cycle 4; final_y=10, pass=1, steps=1.
- pattern=0x0001, length=4, expect_y=00 -> target walks 10, 11, 01, 00; done at cycle 7; final_y=00, pass=1, steps=4.
- pattern=0x0005, length=3, expect_y=11 -> final_y=01, pass=0. A start pulsed during DRIVE is ignored: busy stays 1 and no second done.
- length=0, expect_y=00 -> CLEAR goes straight to CHECK; done at cycle 3; pass=1, steps=0. length=31 with PAT_W=16 -> steps=16.
- abort=1 in the 2nd DRIVE cycle of a length-8 command -> done the next cycle; pass=0; steps=1 (the abort-cycle edge does not count); fsm_w=0. rst=0 during a later DRIVE -> immediate IDLE with fsm_rst=1.
